// File: rtl/hazard_if.sv
// rtl/hazard_if.sv - pipeline hazard signal bundle between datapath and hazard controller
interface hazard_if;
    logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic        RegWriteM, RegWriteW, MemtoRegE;
    logic        PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
    logic        MemReqM, MemReadyM;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM;
    logic        FlushD, FlushE, FlushW;
    logic        MemErr;
    logic [15:0] StallCount;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        output RegWriteM, RegWriteW, MemtoRegE,
        output PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
        output MemReqM, MemReadyM,
        input  ForwardAE, ForwardBE,
        input  StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW,
        input  MemErr, StallCount
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        input  RegWriteM, RegWriteW, MemtoRegE,
        input  PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
        input  MemReqM, MemReadyM,
        output ForwardAE, ForwardBE,
        output StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW,
        output MemErr, StallCount
    );
endinterface

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - forwarding, load-use/branch hazards and memory-wait freeze for a 5-stage pipe
module hazard_controller (
    input  logic    clk,
    input  logic    reset,
    hazard_if.slave hz
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  wait_cnt_q;
    logic        mem_err_q;
    logic [15:0] stall_count_q;
    logic [15:0] stall_count_d;

    logic ld_stall, pc_pend;
    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_w;

    // Register 15 is the PC and is never forwarded; M has the newer value, so it wins over W.
    function automatic logic [1:0] fwd_sel(input logic [3:0] ra, input logic wr_m,
                                           input logic [3:0] wa_m, input logic wr_w,
                                           input logic [3:0] wa_w);
        if (wr_m && (wa_m == ra) && (ra != 4'd15))
            return 2'b10;
        else if (wr_w && (wa_w == ra) && (ra != 4'd15))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign hz.ForwardAE = fwd_sel(hz.RA1E, hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W);
    assign hz.ForwardBE = fwd_sel(hz.RA2E, hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W);

    assign ld_stall = hz.MemtoRegE & ((hz.RA1D == hz.WA3E) | (hz.RA2D == hz.WA3E));
    assign pc_pend  = hz.PCSrcD | hz.PCSrcE | hz.PCSrcM;

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (reset) begin
            unique case (state_q)
                RUN: begin
                    stall_f = ld_stall | pc_pend;
                    stall_d = ld_stall;
                    flush_d = pc_pend | hz.PCSrcW | hz.BranchTakenE;
                    flush_e = ld_stall | hz.BranchTakenE;
                end
                // Whole pipe frozen; only W is bubbled so the stalled M result is not retired twice.
                MEM_WAIT: begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    stall_m = 1'b1;
                    flush_w = 1'b1;
                end
                ERROR: begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    stall_m = 1'b1;
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                    flush_w = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign hz.StallF = stall_f;
    assign hz.StallD = stall_d;
    assign hz.StallE = stall_e;
    assign hz.StallM = stall_m;
    assign hz.FlushD = flush_d;
    assign hz.FlushE = flush_e;
    assign hz.FlushW = flush_w;

    assign stall_count_d = (stall_f && (stall_count_q != 16'hFFFF)) ? stall_count_q + 16'd1
                                                                    : stall_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= 4'd0;
            mem_err_q     <= 1'b0;
            stall_count_q <= 16'd0;
        end else begin
            stall_count_q <= stall_count_d;
            unique case (state_q)
                RUN: begin
                    if (hz.MemReqM && !hz.MemReadyM) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= 4'd0;
                    end
                end
                MEM_WAIT: begin
                    if (hz.MemReadyM) begin
                        state_q <= RUN;
                    end else if (wait_cnt_q == 4'd15) begin
                        state_q   <= ERROR;
                        mem_err_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 4'd1;
                    end
                end
                ERROR: ;
                default: state_q <= RUN;
            endcase
        end
    end

    assign hz.MemErr     = mem_err_q;
    assign hz.StallCount = stall_count_q;
endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - table, directed and random checks of hazard_controller against a reference model
module tb_hazard_controller;
    logic clk = 1'b0;
    logic reset;
    hazard_if hz();

    hazard_controller dut (.clk(clk), .reset(reset), .hz(hz));

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
        logic       RegWriteM, RegWriteW, MemtoRegE;
        logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
        logic       MemReqM, MemReadyM;
    } inp_t;

    typedef struct {
        logic [1:0] fa, fb;
        logic       sf, sd, se, sm, fd, fe, fw;
    } out_t;

    typedef struct {
        inp_t       i;
        logic [1:0] fa, fb;
        logic       sf, sd, fd, fe;
    } vec_t;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: unready wait cycles seen so far (-1 = pipeline running), error latch, stall total.
    int m_waited = -1;
    bit m_err    = 0;
    int m_cnt    = 0;

    function automatic inp_t idle();
        inp_t v;
        v.rst = 1'b1;
        v.RA1D = 4'd1; v.RA2D = 4'd2; v.RA1E = 4'd3; v.RA2E = 4'd4;
        v.WA3E = 4'd6; v.WA3M = 4'd7; v.WA3W = 4'd8;
        v.RegWriteM = 0; v.RegWriteW = 0; v.MemtoRegE = 0;
        v.PCSrcD = 0; v.PCSrcE = 0; v.PCSrcM = 0; v.PCSrcW = 0; v.BranchTakenE = 0;
        v.MemReqM = 0; v.MemReadyM = 0;
        return v;
    endfunction

    function automatic vec_t mkv(input inp_t i, input logic [1:0] fa, input logic [1:0] fb,
                                 input logic sf, input logic sd, input logic fd, input logic fe);
        vec_t t;
        t.i = i; t.fa = fa; t.fb = fb; t.sf = sf; t.sd = sd; t.fd = fd; t.fe = fe;
        return t;
    endfunction

    task automatic drive(input inp_t v);
        reset = v.rst;
        hz.RA1D = v.RA1D; hz.RA2D = v.RA2D; hz.RA1E = v.RA1E; hz.RA2E = v.RA2E;
        hz.WA3E = v.WA3E; hz.WA3M = v.WA3M; hz.WA3W = v.WA3W;
        hz.RegWriteM = v.RegWriteM; hz.RegWriteW = v.RegWriteW; hz.MemtoRegE = v.MemtoRegE;
        hz.PCSrcD = v.PCSrcD; hz.PCSrcE = v.PCSrcE; hz.PCSrcM = v.PCSrcM; hz.PCSrcW = v.PCSrcW;
        hz.BranchTakenE = v.BranchTakenE;
        hz.MemReqM = v.MemReqM; hz.MemReadyM = v.MemReadyM;
    endtask

    function automatic logic [1:0] ref_fwd(input logic [3:0] src, input inp_t v);
        if (src == 4'd15) return 2'b00;
        if (v.RegWriteM && v.WA3M == src) return 2'b10;
        if (v.RegWriteW && v.WA3W == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic out_t ref_out(input inp_t v);
        out_t e;
        bit   lu, pend;
        e.fa = ref_fwd(v.RA1E, v);
        e.fb = ref_fwd(v.RA2E, v);
        lu   = v.MemtoRegE && (v.RA1D == v.WA3E || v.RA2D == v.WA3E);
        pend = v.PCSrcD || v.PCSrcE || v.PCSrcM;
        {e.sf, e.sd, e.se, e.sm, e.fd, e.fe, e.fw} = 7'b0;
        if (!v.rst) return e;
        if (m_err) begin
            {e.sf, e.sd, e.se, e.sm, e.fd, e.fe, e.fw} = 7'b1111111;
        end else if (m_waited >= 0) begin
            {e.sf, e.sd, e.se, e.sm, e.fw} = 5'b11111;
        end else begin
            e.sf = lu || pend;
            e.sd = lu;
            e.fd = pend || v.PCSrcW || v.BranchTakenE;
            e.fe = lu || v.BranchTakenE;
        end
        return e;
    endfunction

    task automatic model_step(input inp_t v, input logic stalled);
        if (stalled) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
        if (m_err) return;
        if (m_waited < 0) begin
            if (v.MemReqM && !v.MemReadyM) m_waited = 0;
        end else if (v.MemReadyM) begin
            m_waited = -1;
        end else begin
            m_waited = m_waited + 1;
            if (m_waited == 16) begin
                m_err    = 1;
                m_waited = -1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, want);
        end
    endtask

    task automatic run_cycle(input inp_t v);
        out_t e;
        @(negedge clk);
        drive(v);
        #1;
        if (!v.rst) begin
            m_waited = -1; m_err = 0; m_cnt = 0;
        end
        e = ref_out(v);
        chk("ForwardAE", {30'd0, hz.ForwardAE}, {30'd0, e.fa});
        chk("ForwardBE", {30'd0, hz.ForwardBE}, {30'd0, e.fb});
        chk("stall_flush", {25'd0, hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushW},
                           {25'd0, e.sf, e.sd, e.se, e.sm, e.fd, e.fe, e.fw});
        chk("MemErr", {31'd0, hz.MemErr}, {31'd0, m_err});
        chk("StallCount", {16'd0, hz.StallCount}, m_cnt);
        if (v.rst) model_step(v, e.sf);
        cyc++;
    endtask

    vec_t tbl[11];
    inp_t v;
    int   base;

    initial begin
        drive(idle());
        reset = 1'b0;

        // Reset: controls quiet, forwarding still live.
        v = idle(); v.rst = 0; v.RegWriteM = 1; v.WA3M = 3; v.RA1E = 3; v.MemtoRegE = 1; v.WA3E = 1;
        v.PCSrcD = 1; v.BranchTakenE = 1;
        run_cycle(v);
        chk("rst_fwdA", {30'd0, hz.ForwardAE}, 32'd2);
        chk("rst_stallF", {31'd0, hz.StallF}, 32'd0);
        chk("rst_count", {16'd0, hz.StallCount}, 32'd0);
        run_cycle(idle());

        v = idle(); v.RegWriteM = 1; v.WA3M = 3; v.RA1E = 3; v.RegWriteW = 1; v.WA3W = 3;
        tbl[0] = mkv(v, 2'b10, 2'b00, 0, 0, 0, 0);
        v.RA1E = 15;
        tbl[1] = mkv(v, 2'b00, 2'b00, 0, 0, 0, 0);
        v = idle(); v.RegWriteW = 1; v.WA3W = 7; v.RA2E = 7; v.RegWriteM = 1; v.WA3M = 2;
        tbl[2] = mkv(v, 2'b00, 2'b01, 0, 0, 0, 0);
        v = idle(); v.WA3M = 4; v.WA3W = 4; v.RA1E = 4; v.RA2E = 4; v.RegWriteW = 1;
        tbl[3] = mkv(v, 2'b01, 2'b01, 0, 0, 0, 0);
        v = idle(); v.RA2E = 15; v.WA3W = 15; v.RegWriteW = 1;
        tbl[4] = mkv(v, 2'b00, 2'b00, 0, 0, 0, 0);
        v = idle(); v.MemtoRegE = 1; v.WA3E = 5; v.RA2D = 5;
        tbl[5] = mkv(v, 2'b00, 2'b00, 1, 1, 0, 1);
        v.MemtoRegE = 0;
        tbl[6] = mkv(v, 2'b00, 2'b00, 0, 0, 0, 0);
        v = idle(); v.PCSrcE = 1;
        tbl[7] = mkv(v, 2'b00, 2'b00, 1, 0, 1, 0);
        v = idle(); v.PCSrcW = 1;
        tbl[8] = mkv(v, 2'b00, 2'b00, 0, 0, 1, 0);
        v = idle(); v.BranchTakenE = 1;
        tbl[9] = mkv(v, 2'b00, 2'b00, 0, 0, 1, 1);
        v = idle(); v.MemtoRegE = 1; v.WA3E = 9; v.RA1D = 9; v.PCSrcM = 1;
        tbl[10] = mkv(v, 2'b00, 2'b00, 1, 1, 1, 1);

        for (int k = 0; k < 11; k++) begin
            run_cycle(tbl[k].i);
            chk($sformatf("tbl%0d_fwd", k), {28'd0, hz.ForwardAE, hz.ForwardBE}, {28'd0, tbl[k].fa, tbl[k].fb});
            chk($sformatf("tbl%0d_ctl", k), {28'd0, hz.StallF, hz.StallD, hz.FlushD, hz.FlushE},
                                            {28'd0, tbl[k].sf, tbl[k].sd, tbl[k].fd, tbl[k].fe});
        end

        // Load-use stalls exactly one cycle's worth.
        run_cycle(idle());
        base = m_cnt;
        v = idle(); v.MemtoRegE = 1; v.WA3E = 5; v.RA2D = 5;
        run_cycle(v);
        run_cycle(idle());
        chk("ldstall_count", {16'd0, hz.StallCount}, base + 1);

        // PC write walking D, E, M, W.
        for (int k = 0; k < 4; k++) begin
            v = idle();
            v.PCSrcD = (k == 0); v.PCSrcE = (k == 1); v.PCSrcM = (k == 2); v.PCSrcW = (k == 3);
            run_cycle(v);
            chk($sformatf("pc%0d", k), {30'd0, hz.StallF, hz.FlushD}, {30'd0, (k < 3), 1'b1});
        end

        // Memory wait: three unready cycles, then ready; branch in E must not flush while frozen.
        v = idle(); v.MemReqM = 1;
        run_cycle(v);
        for (int k = 0; k < 4; k++) begin
            v = idle(); v.MemReqM = 1; v.BranchTakenE = 1; v.MemReadyM = (k == 3);
            run_cycle(v);
            chk($sformatf("wait%0d", k), {25'd0, hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushW},
                                         32'b1111001);
        end
        run_cycle(idle());
        chk("wait_done", {30'd0, hz.StallF, hz.MemErr}, 32'd0);

        // Ready arriving on the last allowed wait cycle still recovers.
        v = idle(); v.MemReqM = 1;
        run_cycle(v);
        for (int k = 0; k < 16; k++) begin
            v.MemReadyM = (k == 15);
            run_cycle(v);
        end
        run_cycle(idle());
        chk("late_ready", {30'd0, hz.StallE, hz.MemErr}, 32'd0);

        // Timeout: 16 unready wait cycles leads to ERROR.
        v = idle(); v.MemReqM = 1;
        run_cycle(v);
        for (int k = 0; k < 16; k++) run_cycle(v);
        v = idle(); v.MemReqM = 1; v.MemReadyM = 1;
        run_cycle(v);
        chk("err_set", {29'd0, hz.MemErr, hz.FlushD, hz.FlushE}, 32'b111);
        run_cycle(idle());
        chk("err_sticky", {31'd0, hz.MemErr}, 32'd1);

        // Sit in ERROR long enough to saturate the stall counter.
        for (int k = 0; k < 65600; k++) begin
            @(negedge clk);
            m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
        end
        run_cycle(idle());
        chk("saturate", {16'd0, hz.StallCount}, 32'hFFFF);

        v = idle(); v.rst = 0;
        run_cycle(v);
        chk("err_reset", {15'd0, hz.MemErr, hz.StallCount}, 32'd0);
        run_cycle(idle());
        chk("post_reset", {28'd0, hz.StallF, hz.StallM, hz.FlushD, hz.FlushW}, 32'd0);

        // Randomised traffic against the model, including resets landing mid-wait.
        for (int k = 0; k < 3000; k++) begin
            v = idle();
            v.rst = ($urandom_range(0, 99) != 0);
            v.RA1D = 4'($urandom_range(0, 3)); v.RA2D = 4'($urandom_range(0, 3));
            v.RA1E = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            v.RA2E = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            v.WA3E = 4'($urandom_range(0, 3));
            v.WA3M = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            v.WA3W = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            v.RegWriteM = 1'($urandom_range(0, 1)); v.RegWriteW = 1'($urandom_range(0, 1));
            v.MemtoRegE = 1'($urandom_range(0, 1));
            v.PCSrcD = ($urandom_range(0, 5) == 0); v.PCSrcE = ($urandom_range(0, 5) == 0);
            v.PCSrcM = ($urandom_range(0, 5) == 0); v.PCSrcW = ($urandom_range(0, 5) == 0);
            v.BranchTakenE = ($urandom_range(0, 5) == 0);
            v.MemReqM = ($urandom_range(0, 3) == 0);
            v.MemReadyM = (k % 500 > 440) ? 1'b0 : 1'($urandom_range(0, 1));
            run_cycle(v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low (0 = reset).
REQ-003 SHALL have ports: RA1D, RA2D  in  4 each  source registers of instruction in Decode.
REQ-004 SHALL have ports: RA1E, RA2E, WA3E  in  4 each  sources and destination in Execute.
REQ-005 SHALL have ports: WA3M, WA3W  in  4 each  destinations in Memory and Writeback.
REQ-006 SHALL have ports: RegWriteM, RegWriteW, MemtoRegE  in  1 each  stage write enables and load-in-Execute flag.
REQ-007 SHALL have ports: PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1 each  PC-write instruction in stage; BranchTakenE  in  1  branch resolved taken in Execute.
REQ-008 SHALL have ports: MemReqM  in  1  load/store in Memory; MemReadyM  in  1  data memory completes this cycle.
REQ-009 SHALL have ports: ForwardAE, ForwardBE  out  2 each  00 = regfile, 01 = ResultW, 10 = ALUResultM.
REQ-010 SHALL have ports: StallF, StallD, StallE, StallM  out  1 each  hold pipeline register; FlushD, FlushE, FlushW  out  1 each  insert bubble.
REQ-011 SHALL have ports: MemErr  out  1  sticky memory timeout; StallCount  out  16  saturating stall-cycle count.

Function
REQ-012 SHALL implement FSM states RUN, MEM_WAIT and ERROR, encoded in 2 bits.
REQ-013 Forwarding SHALL be combinational:
  - ForwardAE = 10 if RegWriteM & WA3M==RA1E & RA1E!=15;
  - else 01 if RegWriteW & WA3W==RA1E & RA1E!=15;
  - else 00.
  - ForwardBE is identical using RA2E. M priority over W.
REQ-014 Load-use: LdStall = MemtoRegE & (RA1D==WA3E | RA2D==WA3E).
REQ-015 PCPend = PCSrcD | PCSrcE | PCSrcM.
REQ-016 In RUN, outputs SHALL be:
  - StallF = LdStall | PCPend
  - StallD = LdStall
  - FlushD = PCPend | PCSrcW | BranchTakenE
  - FlushE = LdStall | BranchTakenE
  - StallE = StallM = FlushW = 0
REQ-017 RUN→MEM_WAIT SHALL occur when MemReqM & !MemReadyM; with MemReadyM=1 in the same cycle as MemReqM, the FSM SHALL remain in RUN (zero-wait access).
REQ-018 In MEM_WAIT, outputs SHALL be:
  - StallF = StallD = StallE = StallM = 1
  - FlushW = 1
  - FlushD = FlushE = 0 (freeze dominates; no in-flight instruction is lost)
  - Forwarding unchanged.
REQ-019 MEM_WAIT→RUN SHALL occur on the edge where MemReadyM=1; during that ready cycle, outputs SHALL still be the MEM_WAIT values (M result is captured into W on that edge).
REQ-020 A 4-bit WaitCnt SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle with MemReadyM=0.
REQ-021 When WaitCnt==15 and MemReadyM=0, the FSM SHALL go MEM_WAIT→ERROR; MemReadyM=1 on that same cycle SHALL take priority (→RUN).
REQ-022 ERROR SHALL be terminal until reset:
  - MemErr = 1
  - all four Stall outputs = 1
  - FlushD = FlushE = FlushW = 1
REQ-023 StallCount SHALL increment on each edge where StallF=1, and saturate at 16'hFFFF (no wrap).
REQ-024 Stall/flush outputs SHALL be combinational from state and inputs; StallCount and MemErr SHALL be registered.

Reset
REQ-025 When reset=0, asynchronously: state = RUN, WaitCnt = 0, MemErr = 0, StallCount = 0.
REQ-026 While reset=0, all Stall/Flush outputs SHALL be 0; Forward outputs follow REQ-013.
REQ-027 Reset asserted mid-MEM_WAIT or in ERROR SHALL return the block to RUN with no residual stall on the first cycle after reset release.

Verification
REQ-028 RegWriteM=1, WA3M=3, RA1E=3, RegWriteW=1, WA3W=3 → ForwardAE=10; change RA1E=15 → ForwardAE=00.
REQ-029 MemtoRegE=1, WA3E=5, RA2D=5 → StallF=StallD=FlushE=1 for one cycle; StallCount increments by 1.
REQ-030 PCSrcD=1 advancing through D, E, M, W over 4 cycles → StallF=1 for cycles 1-3, FlushD=1 for cycles 1-4; BranchTakenE=1 → FlushD=FlushE=1.
REQ-031 MemReqM=1, MemReadyM low for 3 cycles then high → MEM_WAIT for 4 cycles with all stalls and FlushW=1, then RUN, MemErr=0.
REQ-032 MemReqM=1, MemReadyM held 0 → ERROR after 16 wait cycles, MemErr=1 stays set; reset=0 → RUN, MemErr=0, StallCount=0.
